// File: rtl/prom_copier.sv
// Boot-time block copier: reads WORDS words from the PROM port and writes each one
// to RAM, keeping a running modulo-2^32 checksum of everything read.
module prom_copier #(
    parameter int unsigned WORDS     = 1024,
    parameter logic [9:0]  PROM_BASE = 10'h000,
    parameter logic [21:0] RAM_BASE  = 22'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum,
    output logic        prom_stb,
    output logic        prom_we,
    output logic [9:0]  prom_addr,
    input  logic [31:0] prom_data_in,
    input  logic        prom_ack,
    output logic        ram_stb,
    output logic        ram_we,
    output logic [21:0] ram_addr,
    output logic [31:0] ram_data_out,
    input  logic        ram_ack
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [10:0] LAST = 11'(WORDS - 1);

    state_t      state, state_d;
    logic [10:0] count, count_d;
    logic        busy_d, done_d, prom_stb_d, ram_stb_d, ram_we_d;
    logic [31:0] checksum_d, ram_data_d;
    logic [9:0]  prom_addr_d;
    logic [21:0] ram_addr_d;

    assign prom_we = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            checksum     <= '0;
            prom_stb     <= 1'b0;
            prom_addr    <= PROM_BASE;
            ram_stb      <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= RAM_BASE;
            ram_data_out <= '0;
        end else begin
            state        <= state_d;
            count        <= count_d;
            busy         <= busy_d;
            done         <= done_d;
            checksum     <= checksum_d;
            prom_stb     <= prom_stb_d;
            prom_addr    <= prom_addr_d;
            ram_stb      <= ram_stb_d;
            ram_we       <= ram_we_d;
            ram_addr     <= ram_addr_d;
            ram_data_out <= ram_data_d;
        end
    end

    // Each strobe only drops on the edge that samples its ack, so the two
    // strobes never overlap and a PROM ack cannot be seen twice.
    always_comb begin
        state_d     = state;
        count_d     = count;
        busy_d      = busy;
        done_d      = done;
        checksum_d  = checksum;
        prom_stb_d  = prom_stb;
        prom_addr_d = prom_addr;
        ram_stb_d   = ram_stb;
        ram_we_d    = ram_we;
        ram_addr_d  = ram_addr;
        ram_data_d  = ram_data_out;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    count_d     = '0;
                    prom_addr_d = PROM_BASE;
                    ram_addr_d  = RAM_BASE;
                    checksum_d  = '0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    prom_stb_d  = 1'b1;
                    state_d     = RD;
                end
            end
            RD: begin
                if (prom_ack) begin
                    ram_data_d = prom_data_in;
                    checksum_d = checksum + prom_data_in;
                    prom_stb_d = 1'b0;
                    ram_stb_d  = 1'b1;
                    ram_we_d   = 1'b1;
                    state_d    = WR;
                end
            end
            WR: begin
                if (ram_ack) begin
                    ram_stb_d = 1'b0;
                    ram_we_d  = 1'b0;
                    count_d   = count + 11'd1;
                    if (count == LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        prom_addr_d = prom_addr + 10'd1;
                        ram_addr_d  = ram_addr + 22'd1;
                        prom_stb_d  = 1'b1;
                        state_d     = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prom_copier.sv
// Directed bench for prom_copier: three configurations, PROM/RAM bus models and an
// address/data scoreboard filled when each copy is started.
module tb_prom_copier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [2:0]        start, busy, done, prom_stb, prom_we, prom_ack, ram_stb, ram_we, ram_ack;
    logic [2:0][31:0]  checksum, prom_din, ram_dout;
    logic [2:0][9:0]   prom_addr;
    logic [2:0][21:0]  ram_addr;

    logic [31:0] prom_mem [1024];
    logic [2:0]  pack_q;
    int          rwait0, rwait1, rwait2;
    int          ram_delay;
    logic        spur;

    int          checks, errors, wr_cnt;
    logic [1:0]  sel;
    logic [9:0]  exp_pa [$];
    logic [21:0] exp_ra [$];
    logic [31:0] exp_rd [$];

    prom_copier #(.WORDS(4), .PROM_BASE(10'h000), .RAM_BASE(22'h000000)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .checksum(checksum[0]), .prom_stb(prom_stb[0]), .prom_we(prom_we[0]),
        .prom_addr(prom_addr[0]), .prom_data_in(prom_din[0]), .prom_ack(prom_ack[0]),
        .ram_stb(ram_stb[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_data_out(ram_dout[0]), .ram_ack(ram_ack[0]));

    prom_copier #(.WORDS(1024), .PROM_BASE(10'h000), .RAM_BASE(22'h000000)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .checksum(checksum[1]), .prom_stb(prom_stb[1]), .prom_we(prom_we[1]),
        .prom_addr(prom_addr[1]), .prom_data_in(prom_din[1]), .prom_ack(prom_ack[1]),
        .ram_stb(ram_stb[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_data_out(ram_dout[1]), .ram_ack(ram_ack[1]));

    prom_copier #(.WORDS(4), .PROM_BASE(10'h3FE), .RAM_BASE(22'h3FFFFE)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .checksum(checksum[2]), .prom_stb(prom_stb[2]), .prom_we(prom_we[2]),
        .prom_addr(prom_addr[2]), .prom_data_in(prom_din[2]), .prom_ack(prom_ack[2]),
        .ram_stb(ram_stb[2]), .ram_we(ram_we[2]), .ram_addr(ram_addr[2]),
        .ram_data_out(ram_dout[2]), .ram_ack(ram_ack[2]));

    // PROM acks one cycle after seeing stb and toggles while stb is held;
    // RAM acks after ram_delay wait cycles. spur injects acks while idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            rwait0 <= 0;
            rwait1 <= 0;
            rwait2 <= 0;
        end else begin
            pack_q <= prom_stb & ~pack_q;
            rwait0 <= (ram_stb[0] && !ram_ack[0]) ? rwait0 + 1 : 0;
            rwait1 <= (ram_stb[1] && !ram_ack[1]) ? rwait1 + 1 : 0;
            rwait2 <= (ram_stb[2] && !ram_ack[2]) ? rwait2 + 1 : 0;
        end
    end

    assign prom_ack   = pack_q | {3{spur}};
    assign ram_ack[0] = (ram_stb[0] && rwait0 >= ram_delay) || spur;
    assign ram_ack[1] = (ram_stb[1] && rwait1 >= ram_delay) || spur;
    assign ram_ack[2] = (ram_stb[2] && rwait2 >= ram_delay) || spur;
    assign prom_din[0] = prom_mem[prom_addr[0]];
    assign prom_din[1] = prom_mem[prom_addr[1]];
    assign prom_din[2] = prom_mem[prom_addr[2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus transfers of the selected DUT are popped off the scoreboard as they complete.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("stb_exclusive", 64'(prom_stb & ram_stb), 64'd0);
            if (prom_stb[sel] && prom_ack[sel] && !spur) begin
                if (exp_pa.size() == 0) chk("prom_read_pending", 64'(exp_pa.size()), 64'd1);
                else chk("prom_addr", 64'(prom_addr[sel]), 64'(exp_pa.pop_front()));
            end
            if (ram_stb[sel] && ram_ack[sel] && !spur) begin
                chk("ram_we", 64'(ram_we[sel]), 64'd1);
                if (exp_ra.size() == 0) chk("ram_write_pending", 64'(exp_ra.size()), 64'd1);
                else begin
                    chk("ram_addr", 64'(ram_addr[sel]), 64'(exp_ra.pop_front()));
                    chk("ram_data", 64'(ram_dout[sel]), 64'(exp_rd.pop_front()));
                end
                wr_cnt++;
            end
        end
    end

    function automatic logic [9:0] pbase(input int k);
        return (k == 2) ? 10'h3FE : 10'h000;
    endfunction

    function automatic logic [21:0] rbase(input int k);
        return (k == 2) ? 22'h3FFFFE : 22'h000000;
    endfunction

    task automatic check_reset_state();
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy",      64'(busy[2'(k)]),      64'd0);
            chk("rst_done",      64'(done[2'(k)]),      64'd0);
            chk("rst_prom_stb",  64'(prom_stb[2'(k)]),  64'd0);
            chk("rst_prom_we",   64'(prom_we[2'(k)]),   64'd0);
            chk("rst_ram_stb",   64'(ram_stb[2'(k)]),   64'd0);
            chk("rst_ram_we",    64'(ram_we[2'(k)]),    64'd0);
            chk("rst_checksum",  64'(checksum[2'(k)]),  64'd0);
            chk("rst_ram_data",  64'(ram_dout[2'(k)]),  64'd0);
            chk("rst_prom_addr", 64'(prom_addr[2'(k)]), 64'(pbase(k)));
            chk("rst_ram_addr",  64'(ram_addr[2'(k)]),  64'(rbase(k)));
        end
    endtask

    task automatic expect_copy(input logic [9:0] pb, input logic [21:0] rb, input int n,
                               output logic [31:0] sum);
        logic [9:0]  pa;
        logic [21:0] ra;
        pa  = pb;
        ra  = rb;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            exp_pa.push_back(pa);
            exp_ra.push_back(ra);
            exp_rd.push_back(prom_mem[pa]);
            sum = sum + prom_mem[pa];
            pa  = pa + 10'd1;
            ra  = ra + 22'd1;
        end
    endtask

    task automatic pulse_start(input logic [1:0] k);
        @(posedge clk);
        #1 start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
    endtask

    task automatic run_to_done(input logic [1:0] k, input int bound, output int cyc);
        int n;
        n   = 0;
        cyc = 0;
        while (done[k] !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
            if (busy[k] === 1'b1) cyc++;
        end
        chk("done_reached", 64'(done[k]), 64'd1);
        chk("busy_cleared", 64'(busy[k]), 64'd0);
        chk("scoreboard_drained", 64'(exp_ra.size() + exp_pa.size()), 64'd0);
    endtask

    task automatic wait_writes(input int target, input int bound);
        int n;
        n = 0;
        while (wr_cnt < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("write_progress", 64'(wr_cnt >= target), 64'd1);
    endtask

    initial begin
        logic [31:0] sum, full_sum, d0;
        logic [21:0] a0;
        int          cyc, n;
        checks = 0; errors = 0; wr_cnt = 0; sel = 2'd0;
        rst_n = 1'b0; start = '0; spur = 1'b0; ram_delay = 0;
        for (int i = 0; i < 1024; i++) prom_mem[i] = (i < 4) ? 32'(i + 1) : $urandom;

        // Reset state, then 20 idle cycles with spurious acks that must be ignored.
        repeat (3) @(posedge clk);
        #1 check_reset_state();
        rst_n = 1'b1;
        spur  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("idle_no_stb", 64'({prom_stb, ram_stb}), 64'd0);
        end
        spur = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Four words 1..4 with single-cycle RAM ack.
        sel = 2'd0; wr_cnt = 0;
        expect_copy(10'h000, 22'h000000, 4, sum);
        pulse_start(2'd0);
        run_to_done(2'd0, 100, cyc);
        chk("a_busy_cycles", 64'(cyc), 64'd12);
        chk("a_checksum",    64'(checksum[0]), 64'd10);
        chk("a_writes",      64'(wr_cnt), 64'd4);
        chk("a_prom_addr_end", 64'(prom_addr[0]), 64'h003);

        // Slow RAM: outputs must hold while the write is pending.
        sel = 2'd0; wr_cnt = 0; ram_delay = 5;
        expect_copy(10'h000, 22'h000000, 4, sum);
        pulse_start(2'd0);
        chk("a_done_cleared_by_start", 64'(done[0]), 64'd0);
        n = 0;
        while (ram_stb[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_ram_stb_seen", 64'(ram_stb[0]), 64'd1);
        d0 = ram_dout[0];
        a0 = ram_addr[0];
        repeat (5) begin
            @(negedge clk);
            chk("wait_ram_stb",  64'(ram_stb[0]),  64'd1);
            chk("wait_ram_data", 64'(ram_dout[0]), 64'(d0));
            chk("wait_ram_addr", 64'(ram_addr[0]), 64'(a0));
            chk("wait_prom_stb", 64'(prom_stb[0]), 64'd0);
        end
        run_to_done(2'd0, 200, cyc);
        chk("a_slow_checksum", 64'(checksum[0]), 64'(sum));
        ram_delay = 0;

        // Full 1024-word copy.
        sel = 2'd1; wr_cnt = 0;
        expect_copy(10'h000, 22'h000000, 1024, full_sum);
        pulse_start(2'd1);
        run_to_done(2'd1, 4000, cyc);
        chk("b_busy_cycles",   64'(cyc), 64'd3072);
        chk("b_checksum",      64'(checksum[1]), 64'(full_sum));
        chk("b_prom_addr_end", 64'(prom_addr[1]), 64'h3FF);
        chk("b_ram_addr_end",  64'(ram_addr[1]), 64'h3FF);
        chk("b_writes",        64'(wr_cnt), 64'd1024);

        // Re-copy: checksum restarts, start while busy ignored, reset aborts.
        wr_cnt = 0;
        expect_copy(10'h000, 22'h000000, 1024, sum);
        pulse_start(2'd1);
        wait_writes(1, 50);
        chk("b_checksum_restart", 64'(checksum[1]), 64'(prom_mem[0]));
        wait_writes(2, 50);
        pulse_start(2'd1);
        chk("b_busy_after_restart_attempt", 64'(busy[1]), 64'd1);
        wait_writes(5, 50);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        exp_pa.delete(); exp_ra.delete(); exp_rd.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_reset_quiet", 64'({prom_stb, ram_stb, busy}), 64'd0);
        end
        wr_cnt = 0;
        expect_copy(10'h000, 22'h000000, 1024, sum);
        pulse_start(2'd1);
        run_to_done(2'd1, 4000, cyc);
        chk("b_recopy_checksum", 64'(checksum[1]), 64'(full_sum));
        chk("b_recopy_cycles",   64'(cyc), 64'd3072);

        // PROM and RAM address wrap.
        sel = 2'd2; wr_cnt = 0;
        expect_copy(10'h3FE, 22'h3FFFFE, 4, sum);
        pulse_start(2'd2);
        run_to_done(2'd2, 100, cyc);
        chk("c_busy_cycles",   64'(cyc), 64'd12);
        chk("c_checksum",      64'(checksum[2]), 64'(sum));
        chk("c_prom_addr_end", 64'(prom_addr[2]), 64'h001);
        chk("c_ram_addr_end",  64'(ram_addr[2]), 64'h000001);
        chk("c_writes",        64'(wr_cnt), 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
